stream_mux: RTL

Parametrised W-bit, N-channel multiplexor with valid/ready handshakes and a registered output stage. It selects a channel either from an explicit `sel` input (fixed mode) or by round-robin arbitration among valid channels (RR mode). It sits between multiple producers (ALU result, memory read data, I/O ports) and a single consumer bus, and generalises the 16-bit 2:1 combinational mux into a flow-controlled, buffered N:1 stage.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/stream_mux_rr_pick.sv | 30 +++
 rtl/stream_mux.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for stream_mux.
// Optional packet lock is enabled with `define STREAM_MUX_PACKET_LOCK_EN.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Wide enough for any practical channel index or count comparison.
    localparam int CHAN_T_W = 16;
    typedef logic [CHAN_T_W-1:0] chan_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority picker: first requesting channel at or after ptr, wrapping.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CW       = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CW-1:0]       ptr,
    output logic [CW-1:0]       grant,
    output logic                any
);

    int idx;

    // Scan from the farthest offset down so the closest request to ptr wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (req[idx]) begin
                grant = CW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream multiplexor with registered output, fixed or round-robin select.
// `define STREAM_MUX_PACKET_LOCK_EN adds in_last and holds the grant until end of packet.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CW       = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [CW-1:0]             sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef STREAM_MUX_PACKET_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CW-1:0] ptr;
    logic [CW-1:0] rr_grant;
    logic          rr_any;
    logic [CW-1:0] g;
    logic          g_ok;
    logic          can_load;
    logic          xfer;
    logic [CW-1:0] next_ptr;
    logic          locked;
    logic [CW-1:0] lock_chan;

    rr_pick #(.CHANNELS(CHANNELS), .CW(CW)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    always_comb begin
        g    = '0;
        g_ok = 1'b0;
        if (locked) begin
            g    = lock_chan;
            g_ok = 1'b1;
        end else if (mode == MODE_FIXED) begin
            g    = sel;
            g_ok = chan_t'(sel) < chan_t'(CHANNELS);
        end else begin
            g    = rr_grant;
            g_ok = rr_any;
        end
    end

    assign can_load = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++)
            in_ready[i] = g_ok && can_load && !reset && (int'(g) == i);
    end

    assign xfer     = |(in_ready & in_valid);
    assign next_ptr = (int'(g) == CHANNELS - 1) ? '0 : g + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(g)*WIDTH +: WIDTH];
            out_chan  <= g;
            if (mode == MODE_RR) ptr <= next_ptr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_MUX_PACKET_LOCK_EN
    // A non-last word pins the grant to its channel until the last word passes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked    <= 1'b0;
            lock_chan <= '0;
        end else if (xfer) begin
            locked    <= !in_last[g];
            lock_chan <= g;
        end
    end
`else
    assign locked    = 1'b0;
    assign lock_chan = '0;
`endif

endmodule
